// File: rtl/ball_renderer.sv
// rtl/ball_renderer.sv - VGA timing generator that renders ball, two pads and centre net
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   pad_left, pad_right   pad centre y (sampled once per frame into shadows)
//   ball_x, ball_y        ball centre (sampled once per frame into shadows)
//   hsync, vsync          active-low syncs
//   rgb                   pixel colour {r,g,b}
//   frame_start           one-cycle pulse for slot (0,0)
// All outputs are registered and describe the slot the counters held one cycle earlier.
module ball_renderer #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int PAD_WIDTH    = 8,
    parameter int PAD_HEIGHT   = 64,
    parameter int PAD_DISTANCE = 16,
    parameter int BALL_SIZE    = 8,
    parameter int NET_X        = 319
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pad_left,
    input  logic [9:0] pad_right,
    input  logic [9:0] ball_x,
    input  logic [8:0] ball_y,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] LP_X0    = 10'(PAD_DISTANCE);
    localparam logic [9:0] LP_X1    = 10'(PAD_DISTANCE + PAD_WIDTH);
    localparam logic [9:0] RP_X0    = 10'(H_VISIBLE - PAD_DISTANCE - PAD_WIDTH);
    localparam logic [9:0] RP_X1    = 10'(H_VISIBLE - PAD_DISTANCE);
    localparam logic [9:0] NET_X0   = 10'(NET_X);
    localparam logic [9:0] NET_X1   = 10'(NET_X + 1);

    localparam logic signed [11:0] BALL_HALF = 12'(BALL_SIZE / 2);
    localparam logic signed [11:0] PAD_HALF  = 12'(PAD_HEIGHT / 2);

    logic [9:0] h_q, h_d, v_q, v_d;
    logic [9:0] pad_left_q, pad_right_q, ball_x_q;
    logic [8:0] ball_y_q;
    logic       hsync_q, hsync_d, vsync_q, vsync_d, frame_start_q, frame_start_d;
    logic [2:0] rgb_q, rgb_d;

    // Lower bounds that would go negative are pinned to 0 so no wrap-around
    // can make an object reappear at the far edge of the screen.
    function automatic logic signed [11:0] clamp0(input logic signed [11:0] x);
        return (x < 12'sd0) ? 12'sd0 : x;
    endfunction

    logic signed [11:0] h_s, v_s, bx_s, by_s, pl_s, pr_s;
    logic visible, ball_hit, lpad_hit, rpad_hit, net_hit;

    always_comb begin
        h_d = (h_q == H_MAX) ? 10'd0 : h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_MAX) begin
            v_d = (v_q == V_MAX) ? 10'd0 : v_q + 10'd1;
        end

        h_s  = $signed({2'b00, h_q});
        v_s  = $signed({2'b00, v_q});
        bx_s = $signed({2'b00, ball_x_q});
        by_s = $signed({3'b000, ball_y_q});
        pl_s = $signed({2'b00, pad_left_q});
        pr_s = $signed({2'b00, pad_right_q});

        visible  = (h_q < H_VIS) && (v_q < V_VIS);
        ball_hit = (h_s >= clamp0(bx_s - BALL_HALF)) && (h_s < bx_s + BALL_HALF) &&
                   (v_s >= clamp0(by_s - BALL_HALF)) && (v_s < by_s + BALL_HALF);
        lpad_hit = (h_q >= LP_X0) && (h_q < LP_X1) &&
                   (v_s >= clamp0(pl_s - PAD_HALF)) && (v_s <= pl_s + PAD_HALF);
        rpad_hit = (h_q >= RP_X0) && (h_q < RP_X1) &&
                   (v_s >= clamp0(pr_s - PAD_HALF)) && (v_s <= pr_s + PAD_HALF);
        // Dashed net: 16 lines on, 16 lines off.
        net_hit  = ((h_q == NET_X0) || (h_q == NET_X1)) && !v_q[4];

        rgb_d = 3'b000;
        if (visible) begin
            if (ball_hit || lpad_hit || rpad_hit) begin
                rgb_d = 3'b111;
            end else if (net_hit) begin
                rgb_d = 3'b010;
            end
        end

        hsync_d       = !((h_q >= HS_START) && (h_q < HS_END));
        vsync_d       = !((v_q >= VS_START) && (v_q < VS_END));
        frame_start_d = (h_q == 10'd0) && (v_q == 10'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            pad_left_q    <= 10'd240;
            pad_right_q   <= 10'd240;
            ball_x_q      <= 10'd320;
            ball_y_q      <= 9'd240;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= 3'b000;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            // Latch game inputs at the start of vertical blanking so the next
            // visible frame is drawn from one consistent snapshot.
            if ((h_q == 10'd0) && (v_q == V_VIS)) begin
                pad_left_q  <= pad_left;
                pad_right_q <= pad_right;
                ball_x_q    <= ball_x;
                ball_y_q    <= ball_y;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_ball_renderer.sv
// tb/tb_ball_renderer.sv - randomized self-checking bench for ball_renderer
module tb_ball_renderer;
    localparam int HV = 80, HF = 4, HS = 8, HB = 4;
    localparam int VV = 60, VF = 2, VS = 2, VB = 3;
    localparam int PW = 4, PH = 10, PD = 4, BS = 4, NX = 39;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] pad_left = 10'd20, pad_right = 10'd40, ball_x = 10'd30;
    logic [8:0] ball_y = 9'd10;
    logic       hsync, vsync, frame_start;
    logic [2:0] rgb;

    int total = 0;
    int bad = 0;

    ball_renderer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .PAD_WIDTH(PW), .PAD_HEIGHT(PH), .PAD_DISTANCE(PD),
        .BALL_SIZE(BS), .NET_X(NX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pad_left(pad_left), .pad_right(pad_right),
        .ball_x(ball_x), .ball_y(ball_y),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    // Colour of a slot straight from the drawing rules, in plain integers.
    function automatic int pix(input int h, input int v, input int pl, input int pr,
                               input int bx, input int by);
        if (h >= HV || v >= VV) return 0;
        if (h >= bx - BS/2 && h < bx + BS/2 && v >= by - BS/2 && v < by + BS/2) return 7;
        if (h >= PD && h < PD + PW && v >= pl - PH/2 && v <= pl + PH/2) return 7;
        if (h >= HV - PD - PW && h < HV - PD && v >= pr - PH/2 && v <= pr + PH/2) return 7;
        if ((h == NX || h == NX + 1) && ((v / 16) % 2 == 0)) return 2;
        return 0;
    endfunction

    // Model: k counts edges since reset release; edge k outputs slot k mod FT.
    int k = 0;
    int m_pl = 240, m_pr = 240, m_bx = 320, m_by = 240;
    int e_rgb = 0, e_hs = 1, e_vs = 1, e_fs = 0, e_h = 0, e_v = 0, e_frame = 0;
    int run_id = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= 0;
            m_pl <= 240; m_pr <= 240; m_bx <= 320; m_by <= 240;
            e_rgb <= 0; e_hs <= 1; e_vs <= 1; e_fs <= 0;
            e_h <= -1; e_v <= -1; e_frame <= -1;
        end else begin
            e_h     <= (k % FT) % HT;
            e_v     <= (k % FT) / HT;
            e_frame <= k / FT;
            e_rgb   <= pix((k % FT) % HT, (k % FT) / HT, m_pl, m_pr, m_bx, m_by);
            e_hs    <= (((k % FT) % HT) >= HV + HF && ((k % FT) % HT) < HV + HF + HS) ? 0 : 1;
            e_vs    <= (((k % FT) / HT) >= VV + VF && ((k % FT) / HT) < VV + VF + VS) ? 0 : 1;
            e_fs    <= ((k % FT) == 0) ? 1 : 0;
            if ((k % FT) == VV * HT) begin
                m_pl <= int'(pad_left); m_pr <= int'(pad_right);
                m_bx <= int'(ball_x);   m_by <= int'(ball_y);
            end
            k <= k + 1;
        end
    end

    // Hand-computed slots for the first run (inputs 20/40/30/10 latched in frame 0).
    typedef struct { int f; int h; int v; int rgb; int hs; int vs; } lit_t;
    lit_t lits[$];

    function automatic void add_lit(input int f, input int h, input int v,
                                    input int c, input int hs_e, input int vs_e);
        lit_t l;
        l.f = f; l.h = h; l.v = v; l.rgb = c; l.hs = hs_e; l.vs = vs_e;
        lits.push_back(l);
    endfunction

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rgb", int'(rgb), e_rgb);
            chk("hsync", int'(hsync), e_hs);
            chk("vsync", int'(vsync), e_vs);
            chk("frame_start", int'(frame_start), e_fs);
            if (run_id == 0) begin
                foreach (lits[i]) begin
                    if (lits[i].f == e_frame && lits[i].h == e_h && lits[i].v == e_v) begin
                        chk($sformatf("lit_rgb(%0d,%0d)", e_h, e_v), int'(rgb), lits[i].rgb);
                        chk($sformatf("lit_hs(%0d,%0d)", e_h, e_v), int'(hsync), lits[i].hs);
                        chk($sformatf("lit_vs(%0d,%0d)", e_h, e_v), int'(vsync), lits[i].vs);
                    end
                end
            end
        end
    end

    task automatic randomize_inputs();
        pad_left  = ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'($urandom_range(0, 75));
        pad_right = ($urandom_range(0, 7) == 0) ? 10'd0    : 10'($urandom_range(0, 75));
        ball_x    = ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'($urandom_range(0, 90));
        ball_y    = ($urandom_range(0, 7) == 0) ? 9'd511   : 9'($urandom_range(0, 70));
    endtask

    task automatic run_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) randomize_inputs();
        end
    endtask

    initial begin
        // Frame 0 runs on reset shadows (all objects off-screen), frame 1 on 20/40/30/10.
        add_lit(0, 4, 20, 0, 1, 1);
        add_lit(0, 39, 0, 2, 1, 1);
        add_lit(1, 0, 0, 0, 1, 1);
        add_lit(1, 30, 10, 7, 1, 1);
        add_lit(1, 31, 11, 7, 1, 1);
        add_lit(1, 32, 10, 0, 1, 1);
        add_lit(1, 28, 12, 0, 1, 1);
        add_lit(1, 4, 15, 7, 1, 1);
        add_lit(1, 7, 25, 7, 1, 1);
        add_lit(1, 4, 14, 0, 1, 1);
        add_lit(1, 8, 20, 0, 1, 1);
        add_lit(1, 72, 35, 7, 1, 1);
        add_lit(1, 76, 40, 0, 1, 1);
        add_lit(1, 40, 16, 0, 1, 1);
        add_lit(1, 40, 32, 2, 1, 1);
        add_lit(1, 83, 5, 0, 1, 1);
        add_lit(1, 84, 5, 0, 0, 1);
        add_lit(1, 91, 5, 0, 0, 1);
        add_lit(1, 92, 5, 0, 1, 1);
        add_lit(1, 0, 62, 0, 1, 0);
        add_lit(1, 0, 64, 0, 1, 1);

        repeat (3) @(negedge clk);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_rgb", int'(rgb), 0);
        chk("rst_fs", int'(frame_start), 0);
        chk_en = 1'b1;
        rst_n = 1'b1;

        // Keep inputs steady past the frame-0 latch, then randomize.
        repeat (VV * HT + 10) @(negedge clk);
        run_random(3 * FT + 30 * HT - (VV * HT + 10));

        // Asynchronous reset mid-frame, between clock edges.
        #3;
        rst_n = 1'b0;
        run_id = 1;
        #1;
        chk("async_hsync", int'(hsync), 1);
        chk("async_vsync", int'(vsync), 1);
        chk("async_rgb", int'(rgb), 0);
        chk("async_fs", int'(frame_start), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_random(2 * FT + 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ball_renderer.md
BALL_RENDERER -- requirements
Module: ball_renderer

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
  H_VISIBLE, 640, visible pixels per line; H_FRONT, 16; H_SYNC, 96; H_BACK, 48 (horizontal porch/sync, pixels)
  V_VISIBLE, 480, visible lines; V_FRONT, 10; V_SYNC, 2; V_BACK, 33 (vertical porch/sync, lines)
  PAD_WIDTH, 8, pad width px; PAD_HEIGHT, 64, pad height px (even); PAD_DISTANCE, 16, pad gap from screen edge px
  BALL_SIZE, 8, ball side px (even); NET_X, 319, left column of 2-px centre net
REQ-002 The block SHALL have these ports (name direction width meaning):
  clk  in  1  pixel clock, one pixel per cycle, rising edge
  rst_n  in  1  asynchronous, active-low reset
  pad_left  in  10  left pad centre y
  pad_right  in  10  right pad centre y
  ball_x  in  10  ball centre x
  ball_y  in  9  ball centre y
  hsync  out  1  horizontal sync, active low
  vsync  out  1  vertical sync, active low
  rgb  out  3  pixel colour {r,g,b}
  frame_start  out  1  one-cycle pulse marking pixel slot (0,0)
REQ-003 One clock, clk; reset asynchronous, active-low, rst_n; no other clock or enable.

Function
REQ-004 Horizontal counter h SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800) and wrap to 0; vertical counter v SHALL advance by 1 when h wraps, range 0..V_TOTAL-1 (525), wrap to 0.
REQ-005 All outputs SHALL be registered; in the cycle after counters hold (h,v), outputs SHALL describe "slot (h,v)" -- fixed 1-cycle latency, sync and colour aligned.
REQ-006 hsync SHALL be 0 iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751), else 1.
REQ-007 vsync SHALL be 0 iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491), else 1.
REQ-008 frame_start SHALL be 1 exactly for slot (0,0), 0 otherwise.
REQ-009 Shadow registers for all four game inputs SHALL be loaded when counters hold (0, V_VISIBLE); rendering SHALL use shadow values only, so a visible frame never shows mixed input values.
REQ-010 Outside visible area (h >= H_VISIBLE or v >= V_VISIBLE) rgb SHALL be 3'b000.
REQ-011 Ball: visible pixel SHALL be ball if ball_x-BALL_SIZE/2 <= h < ball_x+BALL_SIZE/2 and ball_y-BALL_SIZE/2 <= v < ball_y+BALL_SIZE/2.
REQ-012 Left pad: PAD_DISTANCE <= h < PAD_DISTANCE+PAD_WIDTH and pad_left-PAD_HEIGHT/2 <= v <= pad_left+PAD_HEIGHT/2.
REQ-013 Right pad: H_VISIBLE-PAD_DISTANCE-PAD_WIDTH <= h < H_VISIBLE-PAD_DISTANCE and same inclusive y rule with pad_right.
REQ-014 Net: h in {NET_X, NET_X+1} and v[4] == 0.
REQ-015 Bound arithmetic SHALL use at least 11-bit signed width; lower bounds below 0 clamp to 0, no wrap-around; upper bounds beyond the screen simply clip.
REQ-016 Priority/colour: ball 3'b111 > pads 3'b111 > net 3'b010 > background 3'b000.

Reset
REQ-017 While rst_n=0: h=0, v=0, hsync=1, vsync=1, rgb=3'b000, frame_start=0; shadows = pad_left 240, pad_right 240, ball_x 320, ball_y 240.
REQ-018 Reset assertion mid-frame SHALL take effect immediately (asynchronous); after release, first rising edge SHALL output slot (0,0) with frame_start=1.

Verification
1. Release rst_n -> frame_start=1 on first edge, then every 420000 cycles; never otherwise.
2. Free-run one line -> hsync low exactly 96 consecutive cycles, starting slot h=656; vsync low exactly lines 490-491 (1600 cycles).
3. Hold pad_left=240 for 2 frames -> frame 2: rgb=111 at slots h16..23, v208..272; rgb=000 at (15,240), (24,240), (16,207), (16,273).
4. Change ball_x 320->100 at v=100 of frame N -> frame N ball at h316..323; frame N+1 at h96..103, v236..243.
5. pad_left=10, ball_y=2 -> pad rows 0..42 only, ball rows 0..5 only; nothing drawn at v>=480.
6. Pull rst_n low at v=300 -> same-cycle hsync=1, vsync=1, rgb=000; release -> slot (0,0) resumes, shadows at reset values until first latch.
